// File: rtl/div_pkg.sv
// Shared types and defaults for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int unsigned DIV_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/subtractor_n_bit.sv
// N-bit ripple-borrow subtractor: diff = a - b, borrow_out set when a < b.
module subtractor_n_bit #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    logic bc;

    // Borrow ripples from LSB to MSB through one full-subtractor per bit.
    always_comb begin
        bc   = 1'b0;
        diff = '0;
        for (int i = 0; i < int'(N); i++) begin
            diff[i] = a[i] ^ b[i] ^ bc;
            bc      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc);
        end
        borrow_out = bc;
    end

endmodule

// File: rtl/divider_4_bit_seq.sv
// Sequential restoring unsigned divider, one trial subtraction per cycle.
// Optional div_zero flag port is built when DIV_ZERO_FLAG_EN is defined.
module divider_4_bit_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    div_state_t       state, state_next;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q_reg, r_reg, d_reg;
    logic [WIDTH-1:0] r_sh, r_new, q_new;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic             accept_c, last_c;
    logic             unused_trial_msb;

    assign accept_c = (state == IDLE) && start;
    assign last_c   = (state == CALC) && (count == CW'(WIDTH - 1));

    // Shift {R,Q} left, then subtract the divisor from the widened remainder.
    assign r_sh = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};

    subtractor_n_bit #(.N(WIDTH + 1)) u_sub (
        .a          ({1'b0, r_sh}),
        .b          ({1'b0, d_reg}),
        .diff       (trial),
        .borrow_out (borrow)
    );

    assign unused_trial_msb = trial[WIDTH];
    assign r_new = borrow ? r_sh : trial[WIDTH-1:0];
    assign q_new = {q_reg[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == CW'(WIDTH - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count     <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            d_reg     <= '0;
            quotient  <= '0;
            remainder <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
        end else begin
            ready <= (state_next == IDLE);
            done  <= (state_next == DONE);
            if (accept_c) begin
                q_reg <= dividend;
                d_reg <= divisor;
                r_reg <= '0;
                count <= '0;
            end else if (state == CALC) begin
                q_reg <= q_new;
                r_reg <= r_new;
                count <= count + CW'(1);
                if (last_c) begin
                    quotient  <= q_new;
                    remainder <= r_new;
                end
            end
        end
    end

`ifdef DIV_ZERO_FLAG_EN
    logic dz_pend;

    // Flag captured at acceptance, published together with the results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dz_pend  <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept_c) begin
            dz_pend  <= (divisor == '0);
            div_zero <= 1'b0;
        end else if (last_c) begin
            div_zero <= dz_pend;
        end
    end
`endif

endmodule
